// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between icache and dcache and
// routes acceptance tags and data returns. Optional guard: ARB_STARVE_GUARD_EN.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  ic2arb_command,
  input  logic [63:0] ic2arb_addr,
  input  logic [1:0]  dc2arb_command,
  input  logic [63:0] dc2arb_addr,
  input  logic [63:0] dc2arb_data,
  input  logic [3:0]  mem2arb_response,
  input  logic [3:0]  mem2arb_tag,
  input  logic [63:0] mem2arb_data,
  output logic [1:0]  arb2mem_command,
  output logic [63:0] arb2mem_addr,
  output logic [63:0] arb2mem_data,
  output logic [3:0]  arb2ic_response,
  output logic [3:0]  arb2dc_response,
  output logic [3:0]  arb2ic_tag,
  output logic [3:0]  arb2dc_tag,
  output logic [63:0] arb2ic_data,
  output logic [63:0] arb2dc_data,
  output logic        arb_grant_dc
);

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  logic        ic_req;
  logic        dc_req;
  logic        force_ic;
  logic        grant_dc;
  logic        grant_ic;
  logic [15:0] pending_q;
  logic [15:0] pending_d;
  logic [15:0] owner_q;
  logic [15:0] owner_d;
  logic        ret_hit;
  logic        ret_own;
  logic        tbl_set;

  assign ic_req = (ic2arb_command != BUS_NONE);
  assign dc_req = (dc2arb_command != BUS_NONE);

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [2:0] starve_q;
  logic [2:0] starve_d;

  assign force_ic = ic_req && (starve_q == LIMIT);

  // Count consecutive denied icache cycles, saturating at 7
  always_comb begin
    starve_d = '0;
    if (ic_req && !grant_ic) begin
      starve_d = (starve_q == 3'd7) ? starve_q : starve_q + 3'd1;
    end
  end

  // Starvation counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_limit;
  assign unused_limit = ^STARVE_LIMIT;
  assign force_ic     = 1'b0;
`endif

  assign grant_dc     = dc_req && !force_ic;
  assign grant_ic     = ic_req && !grant_dc;
  assign arb_grant_dc = grant_dc;

  // Forward the granted command and steer the acceptance tag back
  always_comb begin
    arb2mem_command = BUS_NONE;
    arb2mem_addr    = '0;
    arb2mem_data    = '0;
    arb2ic_response = '0;
    arb2dc_response = '0;
    unique case (1'b1)
      grant_dc: begin
        arb2mem_command = dc2arb_command;
        arb2mem_addr    = dc2arb_addr;
        arb2mem_data    = dc2arb_data;
        arb2dc_response = mem2arb_response;
      end
      grant_ic: begin
        arb2mem_command = ic2arb_command;
        arb2mem_addr    = ic2arb_addr;
        arb2ic_response = mem2arb_response;
      end
      default: ;
    endcase
  end

  assign ret_hit = (mem2arb_tag != 4'd0) && pending_q[mem2arb_tag];
  assign ret_own = owner_q[mem2arb_tag];
  assign tbl_set = (mem2arb_response != 4'd0)
                && (arb2mem_command == BUS_LOAD);

  // Route a claimed data return to the controller that owns its tag
  always_comb begin
    arb2ic_tag = '0;
    arb2dc_tag = '0;
    if (ret_hit) begin
      if (ret_own) arb2dc_tag = mem2arb_tag;
      else         arb2ic_tag = mem2arb_tag;
    end
  end

  assign arb2ic_data = mem2arb_data;
  assign arb2dc_data = mem2arb_data;

  // Retire the returning tag, then record a new load; the set wins on a clash
  always_comb begin
    pending_d = pending_q;
    owner_d   = owner_q;
    if (ret_hit) pending_d[mem2arb_tag] = 1'b0;
    if (tbl_set) begin
      pending_d[mem2arb_response] = 1'b1;
      owner_d[mem2arb_response]   = grant_dc;
    end
    pending_d[0] = 1'b0;
    owner_d[0]   = 1'b0;
  end

  // Tag ownership table registers
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q <= '0;
      owner_q   <= '0;
    end else begin
      pending_q <= pending_d;
      owner_q   <= owner_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus random traffic
// checked against a tag-table reference model.
module tb_mem_bus_arbiter;

  localparam logic [1:0] NONE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] STORE = 2'd2;
  localparam int LIMIT = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  ic_cmd;
  logic [63:0] ic_addr;
  logic [1:0]  dc_cmd;
  logic [63:0] dc_addr;
  logic [63:0] dc_data;
  logic [3:0]  m_resp;
  logic [3:0]  m_tag;
  logic [63:0] m_data;
  logic [1:0]  o_cmd;
  logic [63:0] o_addr;
  logic [63:0] o_data;
  logic [3:0]  ic_resp;
  logic [3:0]  dc_resp;
  logic [3:0]  ic_tag;
  logic [3:0]  dc_tag;
  logic [63:0] ic_data;
  logic [63:0] dc_rdata;
  logic        gnt_dc;

  int checks = 0;
  int failures = 0;

  bit mp[16];
  bit mo[16];
  int starve;

  always #5 clock = ~clock;

  mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock            (clock),
    .reset            (reset),
    .ic2arb_command   (ic_cmd),
    .ic2arb_addr      (ic_addr),
    .dc2arb_command   (dc_cmd),
    .dc2arb_addr      (dc_addr),
    .dc2arb_data      (dc_data),
    .mem2arb_response (m_resp),
    .mem2arb_tag      (m_tag),
    .mem2arb_data     (m_data),
    .arb2mem_command  (o_cmd),
    .arb2mem_addr     (o_addr),
    .arb2mem_data     (o_data),
    .arb2ic_response  (ic_resp),
    .arb2dc_response  (dc_resp),
    .arb2ic_tag       (ic_tag),
    .arb2dc_tag       (dc_tag),
    .arb2ic_data      (ic_data),
    .arb2dc_data      (dc_rdata),
    .arb_grant_dc     (gnt_dc)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r,
                       input logic [1:0] icc, input logic [63:0] ica,
                       input logic [1:0] dcc, input logic [63:0] dca,
                       input logic [63:0] dcd, input logic [3:0] rsp,
                       input logic [3:0] tg, input logic [63:0] md);
    reset   = r;
    ic_cmd  = icc;
    ic_addr = ica;
    dc_cmd  = dcc;
    dc_addr = dca;
    dc_data = dcd;
    m_resp  = rsp;
    m_tag   = tg;
    m_data  = md;
  endtask

  // Called at negedge: compare outputs with the model, then advance it.
  task automatic step();
    int g;
    bit icr;
    bit dcr;
    bit hit;
    logic [1:0]  fc;
    logic [63:0] fa;
    logic [63:0] fd;
    icr = (ic_cmd != NONE);
    dcr = (dc_cmd != NONE);
    if (GUARD && icr && starve == LIMIT) g = 1;
    else if (dcr) g = 2;
    else if (icr) g = 1;
    else g = 0;
    fc = (g == 2) ? dc_cmd : (g == 1) ? ic_cmd : NONE;
    fa = (g == 2) ? dc_addr : (g == 1) ? ic_addr : 64'd0;
    fd = (g == 2) ? dc_data : 64'd0;
    hit = (m_tag != 0) && mp[m_tag];
    check("cmd", o_cmd, fc);
    check("addr", o_addr, fa);
    check("wdata", o_data, fd);
    check("ic_resp", ic_resp, (g == 1) ? m_resp : 4'd0);
    check("dc_resp", dc_resp, (g == 2) ? m_resp : 4'd0);
    check("ic_tag", ic_tag, (hit && !mo[m_tag]) ? m_tag : 4'd0);
    check("dc_tag", dc_tag, (hit && mo[m_tag]) ? m_tag : 4'd0);
    check("ic_data", ic_data, m_data);
    check("dc_data", dc_rdata, m_data);
    check("grant_dc", gnt_dc, (g == 2));
    if (reset) begin
      foreach (mp[i]) mp[i] = 1'b0;
      starve = 0;
    end else begin
      if (hit) mp[m_tag] = 1'b0;
      if (m_resp != 0 && fc == LOAD) begin
        mp[m_resp] = 1'b1;
        mo[m_resp] = (g == 2);
      end
      if (icr && g != 1) starve = (starve < 7) ? starve + 1 : 7;
      else starve = 0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic cyc(input logic r,
                     input logic [1:0] icc, input logic [63:0] ica,
                     input logic [1:0] dcc, input logic [63:0] dca,
                     input logic [63:0] dcd, input logic [3:0] rsp,
                     input logic [3:0] tg, input logic [63:0] md);
    drive(r, icc, ica, dcc, dca, dcd, rsp, tg, md);
    @(negedge clock);
    step();
  endtask

  initial begin
    int nic;
    int first_ic;
    foreach (mp[i]) begin
      mp[i] = 1'b0;
      mo[i] = 1'b0;
    end
    starve = 0;
    drive(1'b1, NONE, 0, NONE, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    cyc(1'b1, NONE, 0, NONE, 0, 0, 0, 0, 0);

    // idle outputs after reset
    drive(1'b0, NONE, 0, NONE, 0, 0, 0, 0, 0);
    @(negedge clock);
    check("rst_cmd", o_cmd, NONE);
    check("rst_addr", o_addr, 64'd0);
    check("rst_gnt", gnt_dc, 1'b0);
    step();

    // both request, memory accepts tag 3
    drive(1'b0, LOAD, 64'h100, LOAD, 64'h200, 64'h5, 4'd3, 0, 0);
    @(negedge clock);
    check("both_dc_resp", dc_resp, 4'd3);
    check("both_ic_resp", ic_resp, 4'd0);
    check("both_cmd", o_cmd, LOAD);
    check("both_gnt", gnt_dc, 1'b1);
    step();

    // icache load tag 5, return two cycles later
    cyc(1'b0, LOAD, 64'h300, NONE, 0, 0, 4'd5, 0, 0);
    cyc(1'b0, NONE, 0, NONE, 0, 0, 0, 0, 0);
    drive(1'b0, NONE, 0, NONE, 0, 0, 0, 4'd5, 64'hDEAD);
    @(negedge clock);
    check("t5_ic_tag", ic_tag, 4'd5);
    check("t5_ic_data", ic_data, 64'hDEAD);
    check("t5_dc_tag", dc_tag, 4'd0);
    step();
    drive(1'b0, NONE, 0, NONE, 0, 0, 0, 4'd5, 64'hBEEF);
    @(negedge clock);
    check("t5_cleared", ic_tag, 4'd0);
    step();

    // dcache store tag 7 creates no entry
    cyc(1'b0, NONE, 0, STORE, 64'h400, 64'h77, 4'd7, 0, 0);
    drive(1'b0, NONE, 0, NONE, 0, 0, 0, 4'd7, 64'h1);
    @(negedge clock);
    check("st7_ic_tag", ic_tag, 4'd0);
    check("st7_dc_tag", dc_tag, 4'd0);
    step();

    // same-cycle return and reissue of tag 2
    cyc(1'b0, LOAD, 64'h500, NONE, 0, 0, 4'd2, 0, 0);
    drive(1'b0, NONE, 0, LOAD, 64'h600, 0, 4'd2, 4'd2, 64'h22);
    @(negedge clock);
    check("t2_old_ic", ic_tag, 4'd2);
    check("t2_old_dc", dc_tag, 4'd0);
    step();
    drive(1'b0, NONE, 0, NONE, 0, 0, 0, 4'd2, 64'h23);
    @(negedge clock);
    check("t2_new_dc", dc_tag, 4'd2);
    check("t2_new_ic", ic_tag, 4'd0);
    step();

    // reset discards pending tag 9
    cyc(1'b0, LOAD, 64'h700, NONE, 0, 0, 4'd9, 0, 0);
    cyc(1'b1, NONE, 0, NONE, 0, 0, 0, 0, 0);
    drive(1'b0, NONE, 0, NONE, 0, 0, 0, 4'd9, 64'h9);
    @(negedge clock);
    check("t9_ic_tag", ic_tag, 4'd0);
    check("t9_dc_tag", dc_tag, 4'd0);
    step();

    // continuous contention
    cyc(1'b1, NONE, 0, NONE, 0, 0, 0, 0, 0);
    nic = 0;
    first_ic = 0;
    for (int c = 1; c <= 10; c++) begin
      drive(1'b0, LOAD, 64'h800, LOAD, 64'h900, 0, 0, 0, 0);
      @(negedge clock);
      if (!gnt_dc) begin
        nic++;
        if (first_ic == 0) first_ic = c;
      end
      step();
    end
    check("starve_ic_cnt", nic, GUARD ? 2 : 0);
    check("starve_first", first_ic, GUARD ? 5 : 0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic [1:0] icc;
      logic [1:0] dcc;
      logic [3:0] rsp;
      logic [3:0] tg;
      icc = ($urandom_range(0, 2) != 0) ? LOAD : NONE;
      dcc = 2'($urandom_range(0, 2));
      rsp = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      tg  = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      cyc(($urandom_range(0, 49) == 0), icc, {$urandom, $urandom},
          dcc, {$urandom, $urandom}, {$urandom, $urandom},
          rsp, tg, {$urandom, $urandom});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single processor-memory bus between the instruction-cache controller and the data-cache controller. Each cycle it picks one requester's command to forward to memory and routes the memory's same-cycle response (accepted tag or 0) back to that requester. A 15-entry tag-ownership table steers each later data return (tag, data) to the controller that issued the load. It sits between the two cache controllers and the memory model, replacing their direct memory connection.

## Interface
- STARVE_LIMIT, default 4: consecutive denied icache cycles before icache gets forced priority. Used only with the guard compiled in.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ic2arb_command  in  2  icache command: `BUS_NONE` or `BUS_LOAD`.
- ic2arb_addr  in  64  icache request address.
- dc2arb_command  in  2  dcache command: `BUS_NONE`, `BUS_LOAD` or `BUS_STORE`.
- dc2arb_addr  in  64  dcache request address.
- dc2arb_data  in  64  dcache store data.
- mem2arb_response  in  4  memory acceptance tag; 0 means not accepted.
- mem2arb_tag  in  4  data-return tag; 0 means no return this cycle.
- mem2arb_data  in  64  data-return payload.
- arb2mem_command  out  2  forwarded command.
- arb2mem_addr  out  64  forwarded address.
- arb2mem_data  out  64  forwarded store data; equals dc2arb_data when dcache is granted, else 0.
- arb2ic_response, arb2dc_response  out  4  per-requester acceptance tag.
- arb2ic_tag, arb2dc_tag  out  4  per-requester data-return tag.
- arb2ic_data, arb2dc_data  out  64  return data; both always driven with mem2arb_data.
- arb_grant_dc  out  1  1 when dcache holds the bus this cycle (debug/perf).

## Operation
- Grant, combinational:
  - If dc2arb_command != `BUS_NONE`, grant dcache.
  - Otherwise, if ic2arb_command != `BUS_NONE`, grant icache.
  - Otherwise, no grant: forward `BUS_NONE`, address 0, data 0.
- Response routing: mem2arb_response goes to the granted requester only. The other requester's response is 0.
- Ownership table: owner[1..15] (0 = ic, 1 = dc) and pending[1..15].
  - Write condition: mem2arb_response != 0 and the forwarded command is `BUS_LOAD`.
  - On that condition, at posedge set pending[response] = 1 and owner[response] = granted requester.
  - A `BUS_STORE` acceptance creates no entry.
- Return routing: when mem2arb_tag != 0 and pending[tag] = 1:
  - drive mem2arb_tag to the owner's tag output, and 0 to the other;
  - clear pending[tag] at posedge.
- Unclaimed return (pending[tag] = 0): both tag outputs are 0 and the return is dropped.
- Same-cycle clear and set of one tag: the return is routed to the old owner, then the set wins, so pending stays 1 with the new owner.
- Tag 0 is never written into the table.

## Timing
- Grant, forwarding and both routings are zero-latency (combinational). Only the table and the starvation counter are registered.
- Requesters hold their command until they see a nonzero response. Re-arbitration happens every cycle; there are no locked grants.
- Reset values: pending all 0, starvation counter 0.
- Outputs with idle inputs: all commands `BUS_NONE`, addresses/responses/tags 0, arb_grant_dc 0.
- Reset mid-transaction discards all pending entries. Returns arriving after reset are dropped.

## Configuration
- ARB_STARVE_GUARD_EN defined: add a 3-bit saturating counter.
  - Increments each cycle icache requests but is not granted.
  - Clears when icache is granted or is idle.
  - When counter == STARVE_LIMIT, icache wins that cycle even if dcache requests.
  - The counter clears after icache is granted, whether or not memory accepts.
- Not defined: strict dcache priority, no counter logic.

## Test plan
- Both request, memory gives response 3: dcache sees 3, icache sees 0, arb2mem_command = dcache command, arb_grant_dc = 1.
- icache load alone accepted with tag 5; two cycles later mem2arb_tag = 5, data 64'hDEAD: arb2ic_tag = 5, data 64'hDEAD, arb2dc_tag = 0; pending[5] cleared.
- dcache store accepted with tag 7; later mem2arb_tag = 7: both tag outputs 0 and no table entry ever set.
- Same cycle: return of tag 2 (owner ic) and new dcache load accepted as tag 2: icache gets tag 2 that cycle; next return of tag 2 goes to dcache.
- With ARB_STARVE_GUARD_EN and STARVE_LIMIT = 4, both requesting continuously: dcache granted 4 cycles, icache granted cycle 5, pattern repeats. Without the macro, icache is never granted.
- Reset asserted with tag 9 pending; later mem2arb_tag = 9: both tag outputs 0.
